// File: rtl/stamped_stream_arbiter.sv
// Two-input AXI4-Stream packet arbiter: oldest-timestamp or round-robin selection,
// whole packets forwarded as a unit, per-input forwarded-packet counters.
module stamped_stream_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int TIMESTAMP_WIDTH      = 64,
    parameter int TIMESTAMP_POS        = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [1:0]                           port_en,
    input  logic                                 ts_order_en,

    input  logic [C_M_AXIS_DATA_WIDTH-1:0]       s_axis_0_tdata,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]      s_axis_0_tuser,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]     s_axis_0_tstrb,
    input  logic                                 s_axis_0_tvalid,
    input  logic                                 s_axis_0_tlast,
    output logic                                 s_axis_0_tready,

    input  logic [C_M_AXIS_DATA_WIDTH-1:0]       s_axis_1_tdata,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]      s_axis_1_tuser,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]     s_axis_1_tstrb,
    input  logic                                 s_axis_1_tvalid,
    input  logic                                 s_axis_1_tlast,
    output logic                                 s_axis_1_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,

    output logic [31:0]                          pkt_cnt_0,
    output logic [31:0]                          pkt_cnt_1
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                     state, state_nxt;
    logic                       grant, grant_nxt;
    logic                       rr_next, rr_next_nxt;
    logic [31:0]                cnt0_q, cnt1_q;

    logic                       elig0, elig1;
    logic [TIMESTAMP_WIDTH-1:0] ts0, ts1;
    logic                       last_hs;

    assign elig0   = s_axis_0_tvalid & port_en[0];
    assign elig1   = s_axis_1_tvalid & port_en[1];
    assign ts0     = s_axis_0_tuser[TIMESTAMP_POS +: TIMESTAMP_WIDTH];
    assign ts1     = s_axis_1_tuser[TIMESTAMP_POS +: TIMESTAMP_WIDTH];
    assign last_hs = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    assign pkt_cnt_0 = cnt0_q;
    assign pkt_cnt_1 = cnt1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 1'b0;
            rr_next <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_next <= rr_next_nxt;
        end
    end

    // Ties on equal stamps, and all decisions in plain mode, go to rr_next.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        rr_next_nxt = rr_next;
        case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    state_nxt = SEND;
                    if (elig0 && elig1) begin
                        if (ts_order_en && (ts0 != ts1))
                            grant_nxt = (ts1 < ts0);
                        else
                            grant_nxt = rr_next;
                    end else begin
                        grant_nxt = elig1;
                    end
                end
            end
            SEND: begin
                if (last_hs) begin
                    state_nxt   = IDLE;
                    rr_next_nxt = ~grant;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata    = s_axis_0_tdata;
        m_axis_tuser    = s_axis_0_tuser;
        m_axis_tstrb    = s_axis_0_tstrb;
        m_axis_tlast    = s_axis_0_tlast;
        m_axis_tvalid   = 1'b0;
        s_axis_0_tready = 1'b0;
        s_axis_1_tready = 1'b0;
        if (state == SEND) begin
            if (grant) begin
                m_axis_tdata    = s_axis_1_tdata;
                m_axis_tuser    = s_axis_1_tuser;
                m_axis_tstrb    = s_axis_1_tstrb;
                m_axis_tlast    = s_axis_1_tlast;
                m_axis_tvalid   = s_axis_1_tvalid;
                s_axis_1_tready = m_axis_tready;
            end else begin
                m_axis_tvalid   = s_axis_0_tvalid;
                s_axis_0_tready = m_axis_tready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (last_hs) begin
            if (grant)
                cnt1_q <= cnt1_q + 32'd1;
            else
                cnt0_q <= cnt0_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_stamped_stream_arbiter.sv
// Directed testbench for stamped_stream_arbiter: queued source packets, per-cycle
// output capture, hand-built expected beat sequences.
module tb_stamped_stream_arbiter;

    typedef struct packed {
        logic [255:0] data;
        logic [127:0] user;
        logic [31:0]  strb;
        logic         last;
    } beat_t;

    logic         clk;
    logic         reset;
    logic [1:0]   port_en;
    logic         ts_order_en;
    logic [255:0] s_axis_0_tdata, s_axis_1_tdata, m_axis_tdata;
    logic [127:0] s_axis_0_tuser, s_axis_1_tuser, m_axis_tuser;
    logic [31:0]  s_axis_0_tstrb, s_axis_1_tstrb, m_axis_tstrb;
    logic         s_axis_0_tvalid, s_axis_0_tlast, s_axis_0_tready;
    logic         s_axis_1_tvalid, s_axis_1_tlast, s_axis_1_tready;
    logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [31:0]  pkt_cnt_0, pkt_cnt_1;

    int n_cmp = 0;
    int n_err = 0;

    beat_t src0[$], src1[$], outq[$], exp_q[$];
    logic  vq[$];
    int    i0, i1;
    logic  s1_rdy_seen;

    stamped_stream_arbiter #(
        .C_M_AXIS_DATA_WIDTH (256),
        .C_M_AXIS_TUSER_WIDTH(128),
        .TIMESTAMP_WIDTH     (64),
        .TIMESTAMP_POS       (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .port_en        (port_en),
        .ts_order_en    (ts_order_en),
        .s_axis_0_tdata (s_axis_0_tdata),
        .s_axis_0_tuser (s_axis_0_tuser),
        .s_axis_0_tstrb (s_axis_0_tstrb),
        .s_axis_0_tvalid(s_axis_0_tvalid),
        .s_axis_0_tlast (s_axis_0_tlast),
        .s_axis_0_tready(s_axis_0_tready),
        .s_axis_1_tdata (s_axis_1_tdata),
        .s_axis_1_tuser (s_axis_1_tuser),
        .s_axis_1_tstrb (s_axis_1_tstrb),
        .s_axis_1_tvalid(s_axis_1_tvalid),
        .s_axis_1_tlast (s_axis_1_tlast),
        .s_axis_1_tready(s_axis_1_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tstrb   (m_axis_tstrb),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .pkt_cnt_0      (pkt_cnt_0),
        .pkt_cnt_1      (pkt_cnt_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    // Beat tag {C0, src, pkt, beat}; stamp only on the first beat of a packet.
    function automatic beat_t mk(input int src, input int pkt, input int b, input int n,
                                 input logic [63:0] stamp);
        beat_t r;
        logic [31:0] tag;
        tag    = {8'hC0, 8'(src), 8'(pkt), 8'(b)};
        r.data = {~tag, 192'h0, tag};
        r.user = (b == 0) ? {32'h0, stamp, tag} : {96'h0, tag};
        r.strb = (b == n - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        r.last = (b == n - 1);
        return r;
    endfunction

    task automatic add_pkt(input int src, input int pkt, input int n, input logic [63:0] stamp);
        for (int b = 0; b < n; b++) begin
            if (src == 0) src0.push_back(mk(src, pkt, b, n, stamp));
            else          src1.push_back(mk(src, pkt, b, n, stamp));
        end
    endtask

    task automatic add_exp(input int src, input int pkt, input int n, input logic [63:0] stamp);
        for (int b = 0; b < n; b++) exp_q.push_back(mk(src, pkt, b, n, stamp));
    endtask

    task automatic drive();
        beat_t b;
        if (i0 < src0.size()) begin
            b = src0[i0];
            s_axis_0_tvalid = 1'b1;
        end else begin
            b = '0;
            s_axis_0_tvalid = 1'b0;
        end
        s_axis_0_tdata = b.data; s_axis_0_tuser = b.user;
        s_axis_0_tstrb = b.strb; s_axis_0_tlast = b.last;
        if (i1 < src1.size()) begin
            b = src1[i1];
            s_axis_1_tvalid = 1'b1;
        end else begin
            b = '0;
            s_axis_1_tvalid = 1'b0;
        end
        s_axis_1_tdata = b.data; s_axis_1_tuser = b.user;
        s_axis_1_tstrb = b.strb; s_axis_1_tlast = b.last;
    endtask

    // Sample at negedge, advance sources just after the following posedge.
    task automatic cycle();
        logic hs0, hs1;
        @(negedge clk);
        vq.push_back(m_axis_tvalid);
        if (s_axis_1_tready) s1_rdy_seen = 1'b1;
        hs0 = s_axis_0_tvalid && s_axis_0_tready;
        hs1 = s_axis_1_tvalid && s_axis_1_tready;
        if (m_axis_tvalid && m_axis_tready)
            outq.push_back({m_axis_tdata, m_axis_tuser, m_axis_tstrb, m_axis_tlast});
        @(posedge clk);
        #1;
        if (hs0) i0++;
        if (hs1) i1++;
        drive();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src0.delete(); src1.delete(); exp_q.delete();
        i0 = 0; i1 = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        outq.delete(); vq.delete();
        s1_rdy_seen = 1'b0;
    endtask

    task automatic test_reset();
        port_en = 2'b11; ts_order_en = 1'b0; m_axis_tready = 1'b1;
        do_reset();
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_mvalid got=%b exp=0", m_axis_tvalid); end
        n_cmp++; if (s_axis_0_tready !== 1'b0) begin n_err++; $display("FAIL rst_ready0 got=%b exp=0", s_axis_0_tready); end
        n_cmp++; if (s_axis_1_tready !== 1'b0) begin n_err++; $display("FAIL rst_ready1 got=%b exp=0", s_axis_1_tready); end
        n_cmp++; if (pkt_cnt_0 !== 32'd0) begin n_err++; $display("FAIL rst_cnt0 got=%h exp=0", pkt_cnt_0); end
        n_cmp++; if (pkt_cnt_1 !== 32'd0) begin n_err++; $display("FAIL rst_cnt1 got=%h exp=0", pkt_cnt_1); end
    endtask

    task automatic test_single_input();
        logic [5:0] vpat;
        beat_t got;
        port_en = 2'b11; ts_order_en = 1'b0; m_axis_tready = 1'b1;
        do_reset();
        add_pkt(0, 1, 3, 64'h10); add_exp(0, 1, 3, 64'h10);
        drive();
        run(6);
        for (int k = 0; k < 6; k++) vpat[k] = vq[k];
        n_cmp++; if (vpat !== 6'b001110) begin n_err++; $display("FAIL single_valid_pattern got=%b exp=001110", vpat); end
        n_cmp++; if (outq.size() != 3) begin n_err++; $display("FAIL single_beats got=%0d exp=3", outq.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (k < outq.size()) ? outq[k] : '0;
            n_cmp++; if (got !== exp_q[k]) begin n_err++; $display("FAIL single_beat%0d got=%h exp=%h", k, got.data[31:0], exp_q[k].data[31:0]); end
        end
        n_cmp++; if (pkt_cnt_0 !== 32'd1) begin n_err++; $display("FAIL single_cnt0 got=%0d exp=1", pkt_cnt_0); end
        n_cmp++; if (s1_rdy_seen !== 1'b0) begin n_err++; $display("FAIL single_ready1 got=%b exp=0", s1_rdy_seen); end
    endtask

    task automatic test_ts_order();
        logic [6:0] vpat;
        beat_t got;
        port_en = 2'b11; ts_order_en = 1'b1; m_axis_tready = 1'b1;
        do_reset();
        add_pkt(0, 2, 2, 64'h100);
        add_pkt(1, 2, 2, 64'h0FF);
        add_exp(1, 2, 2, 64'h0FF);
        add_exp(0, 2, 2, 64'h100);
        drive();
        run(8);
        for (int k = 0; k < 7; k++) vpat[k] = vq[k];
        n_cmp++; if (vpat !== 7'b0110110) begin n_err++; $display("FAIL ts_bubble_pattern got=%b exp=0110110", vpat); end
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (k < outq.size()) ? outq[k] : '0;
            n_cmp++; if (got !== exp_q[k]) begin n_err++; $display("FAIL ts_beat%0d got=%h exp=%h", k, got.data[31:0], exp_q[k].data[31:0]); end
        end
        n_cmp++; if (pkt_cnt_1 !== 32'd1) begin n_err++; $display("FAIL ts_cnt1 got=%0d exp=1", pkt_cnt_1); end
    endtask

    task automatic test_equal_stamps();
        beat_t got;
        port_en = 2'b11; ts_order_en = 1'b1; m_axis_tready = 1'b1;
        do_reset();
        add_pkt(0, 3, 2, 64'h500); add_pkt(0, 4, 2, 64'h500);
        add_pkt(1, 3, 2, 64'h500); add_pkt(1, 4, 2, 64'h500);
        add_exp(0, 3, 2, 64'h500); add_exp(1, 3, 2, 64'h500);
        add_exp(0, 4, 2, 64'h500); add_exp(1, 4, 2, 64'h500);
        drive();
        run(14);
        n_cmp++; if (outq.size() != 8) begin n_err++; $display("FAIL eq_beats got=%0d exp=8", outq.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (k < outq.size()) ? outq[k] : '0;
            n_cmp++; if (got !== exp_q[k]) begin n_err++; $display("FAIL eq_beat%0d got=%h exp=%h", k, got.data[31:0], exp_q[k].data[31:0]); end
        end
        n_cmp++; if (pkt_cnt_0 !== 32'd2) begin n_err++; $display("FAIL eq_cnt0 got=%0d exp=2", pkt_cnt_0); end
        n_cmp++; if (pkt_cnt_1 !== 32'd2) begin n_err++; $display("FAIL eq_cnt1 got=%0d exp=2", pkt_cnt_1); end
    endtask

    task automatic test_port_disable();
        beat_t got;
        port_en = 2'b01; ts_order_en = 1'b0; m_axis_tready = 1'b1;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            add_pkt(0, 5 + p, 1, 64'h900);
            add_exp(0, 5 + p, 1, 64'h900);
        end
        add_pkt(1, 5, 1, 64'h1); add_pkt(1, 6, 1, 64'h2);
        drive();
        run(12);
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (k < outq.size()) ? outq[k] : '0;
            n_cmp++; if (got !== exp_q[k]) begin n_err++; $display("FAIL pen_beat%0d got=%h exp=%h", k, got.data[31:0], exp_q[k].data[31:0]); end
        end
        n_cmp++; if (outq.size() != 3) begin n_err++; $display("FAIL pen_beats got=%0d exp=3", outq.size()); end
        n_cmp++; if (s1_rdy_seen !== 1'b0) begin n_err++; $display("FAIL pen_ready1 got=%b exp=0", s1_rdy_seen); end
        n_cmp++; if (pkt_cnt_1 !== 32'd0) begin n_err++; $display("FAIL pen_cnt1 got=%0d exp=0", pkt_cnt_1); end
        n_cmp++; if (pkt_cnt_0 !== 32'd3) begin n_err++; $display("FAIL pen_cnt0 got=%0d exp=3", pkt_cnt_0); end
    endtask

    task automatic test_backpressure();
        logic [7:0] vpat;
        logic [9:0] rdy_pat;
        beat_t got;
        rdy_pat = 10'b1111110011;
        port_en = 2'b11; ts_order_en = 1'b0;
        do_reset();
        add_pkt(0, 8, 4, 64'h20); add_exp(0, 8, 4, 64'h20);
        add_pkt(1, 8, 2, 64'h10);
        drive();
        for (int c = 0; c < 10; c++) begin
            m_axis_tready = rdy_pat[c];
            cycle();
            if (c == 1) port_en = 2'b00;
        end
        for (int k = 0; k < 8; k++) vpat[k] = vq[k];
        n_cmp++; if (vpat !== 8'b01111110) begin n_err++; $display("FAIL bp_valid_pattern got=%b exp=01111110", vpat); end
        n_cmp++; if (outq.size() != 4) begin n_err++; $display("FAIL bp_beats got=%0d exp=4", outq.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (k < outq.size()) ? outq[k] : '0;
            n_cmp++; if (got !== exp_q[k]) begin n_err++; $display("FAIL bp_beat%0d got=%h exp=%h", k, got.data[31:0], exp_q[k].data[31:0]); end
        end
        n_cmp++; if (pkt_cnt_0 !== 32'd1) begin n_err++; $display("FAIL bp_cnt0 got=%0d exp=1", pkt_cnt_0); end
        n_cmp++; if (s1_rdy_seen !== 1'b0) begin n_err++; $display("FAIL bp_ready1 got=%b exp=0", s1_rdy_seen); end
    endtask

    task automatic test_reset_midpacket_and_wrap();
        beat_t got;
        port_en = 2'b11; ts_order_en = 1'b0; m_axis_tready = 1'b1;
        do_reset();
        add_pkt(0, 9, 1, 64'h30);
        add_pkt(0, 10, 5, 64'h40);
        exp_q.push_back(mk(0, 9, 0, 1, 64'h30));
        add_exp(0, 10, 5, 64'h40);
        drive();
        run(4);
        reset = 1'b1; m_axis_tready = 1'b0;
        cycle();
        reset = 1'b0; m_axis_tready = 1'b1;
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_mvalid got=%b exp=0", m_axis_tvalid); end
        n_cmp++; if (s_axis_0_tready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready0 got=%b exp=0", s_axis_0_tready); end
        n_cmp++; if (s_axis_1_tready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready1 got=%b exp=0", s_axis_1_tready); end
        n_cmp++; if (pkt_cnt_0 !== 32'd0) begin n_err++; $display("FAIL mid_rst_cnt0 got=%0d exp=0", pkt_cnt_0); end
        run(6);
        n_cmp++; if (outq.size() != 6) begin n_err++; $display("FAIL mid_beats got=%0d exp=6", outq.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (k < outq.size()) ? outq[k] : '0;
            n_cmp++; if (got !== exp_q[k]) begin n_err++; $display("FAIL mid_beat%0d got=%h exp=%h", k, got.data[31:0], exp_q[k].data[31:0]); end
        end
        n_cmp++; if (pkt_cnt_0 !== 32'd1) begin n_err++; $display("FAIL mid_cnt0 got=%0d exp=1", pkt_cnt_0); end

        force dut.cnt0_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt0_q;
        run(1);
        n_cmp++; if (pkt_cnt_0 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload got=%h exp=ffffffff", pkt_cnt_0); end
        add_pkt(0, 11, 1, 64'h50);
        drive();
        run(3);
        n_cmp++; if (pkt_cnt_0 !== 32'd0) begin n_err++; $display("FAIL wrap_cnt0 got=%h exp=0", pkt_cnt_0); end
        n_cmp++; if (pkt_cnt_1 !== 32'd0) begin n_err++; $display("FAIL wrap_cnt1 got=%h exp=0", pkt_cnt_1); end
    endtask

    initial begin
        reset = 1'b1; port_en = 2'b11; ts_order_en = 1'b0; m_axis_tready = 1'b0;
        i0 = 0; i1 = 0; s1_rdy_seen = 1'b0;
        drive();
        test_reset();
        test_single_input();
        test_ts_order();
        test_equal_stamps();
        test_port_disable();
        test_backpressure();
        test_reset_midpacket_and_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stamped_stream_arbiter.md
# stamped_stream_arbiter

- Merges two timestamped AXI4-Stream packet streams onto one master stream, one whole packet at a time.
- Each input comes from a timestamp-insertion stage and carries its 64-bit arrival stamp in tuser[95:32] of the first beat.
- Sits between the per-port timestamp stages and the shared downstream path (DMA/monitor pipeline).
- Selects by oldest stamp or by plain round-robin, and counts forwarded packets per input.

## Interface

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, tdata width of all streams.
- C_M_AXIS_TUSER_WIDTH, 128, tuser width of all streams; must be ≥ 96.
- TIMESTAMP_WIDTH, 64, stamp field width.
- TIMESTAMP_POS, 32, LSB position of the stamp field in tuser.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- port_en  in  2  per-input enable; a disabled input is never granted.
- ts_order_en  in  1  1 = oldest-stamp selection, 0 = pure round-robin.
- s_axis_0_tdata / _tuser / _tstrb / _tvalid / _tlast  in  DATA / TUSER / DATA/8 / 1 / 1  input stream 0.
- s_axis_0_tready  out  1  ready for input stream 0.
- s_axis_1_* (same set as input 0)  in/out  same widths  input stream 1.
- m_axis_tdata / _tuser / _tstrb / _tvalid / _tlast  out  DATA / TUSER / DATA/8 / 1 / 1  merged output stream.
- m_axis_tready  in  1  downstream ready.
- pkt_cnt_0, pkt_cnt_1  out  32 each  packets forwarded per input.

## Operation

- State machine with two states, IDLE and SEND. Registers: state, grant (1 bit), rr_next (1 bit), pkt_cnt_0, pkt_cnt_1.
- Eligible input i: s_axis_i_tvalid=1 and port_en[i]=1, sampled in IDLE.
- IDLE, no eligible input: stay in IDLE.
- IDLE, one eligible input: grant ← that input; go to SEND.
- IDLE, both eligible, ts_order_en=1:
  - Grant the input whose tuser[TIMESTAMP_POS+63:TIMESTAMP_POS] is strictly smaller (unsigned 64-bit compare, no wrap handling).
  - Equal stamps: grant rr_next.
- IDLE, both eligible, ts_order_en=0: grant rr_next.
- SEND outputs:
  - m_axis_* = s_axis_grant_* (combinational mux).
  - s_axis_grant_tready = m_axis_tready; the other input's tready = 0.
- SEND, on m_axis_tvalid & m_axis_tready & m_axis_tlast:
  - pkt_cnt_grant increments (32-bit, wraps 0xFFFFFFFF→0).
  - rr_next ← ~grant.
  - Go to IDLE.
- In IDLE: m_axis_tvalid=0, both s_axis_*_tready=0, m_axis_tdata/tuser/tstrb/tlast = input 0 values (don't-care).
- port_en and ts_order_en are sampled only in IDLE. Changes during SEND never truncate the packet in flight.
- The arbiter never drops, reorders or modifies beats; tuser passes through unchanged.

## Timing

- Reset values: state=IDLE, grant=0, rr_next=0, pkt_cnt_0=pkt_cnt_1=0, m_axis_tvalid=0, s_axis_0_tready=s_axis_1_tready=0.
- Reset asserted mid-packet: next cycle is IDLE. The rest of that packet is left at the input and is later forwarded as if it were a new packet; upstream is responsible for flushing it.
- Decision latency: first beat appears on m_axis one cycle after an eligible input is seen in IDLE.
- Throughput in SEND: one beat per cycle while m_axis_tready=1.
- Each packet boundary costs exactly one IDLE bubble cycle.
- m_axis_tvalid may only fall after a handshake or in IDLE, never while m_axis_tready=0 mid-beat. This is AXI-stable provided the inputs are AXI-stable.
- Counter update is visible one cycle after the last-beat handshake.
- Single-beat packet (tlast on the first beat): SEND lasts one handshake cycle, then IDLE.

## Test plan

- Reset, then input 0 alone sends a 3-beat packet with m_axis_tready=1 → m_axis_tvalid high for cycles 2–4 after tvalid, data matches, pkt_cnt_0=1, s_axis_1_tready stays 0.
- ts_order_en=1, both inputs valid simultaneously, stamps 0x100 (in0) and 0x0FF (in1) → input 1's packet first, then input 0's, with exactly one bubble cycle between them.
- ts_order_en=1, equal stamps 0x500 on both, repeated 4 times → grants alternate 0,1,0,1; final counts pkt_cnt_0=2, pkt_cnt_1=2.
- ts_order_en=0, port_en=2'b01, both inputs continuously valid → only input 0 granted; s_axis_1_tready never 1; pkt_cnt_1=0.
- Backpressure: m_axis_tready toggled 1,0,0,1 during a 4-beat packet; also port_en cleared mid-packet → all 4 beats delivered in order, no beat duplicated, tlast on beat 4, count +1.
- Reset pulsed on beat 2 of 5; separately, pkt_cnt_0 preloaded near wrap (0xFFFFFFFF) via 2^32-1 packets or a forced value → after reset all outputs at reset values; counter wraps to 0 on the next completed packet.
